mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: MEM_AW, 11, memory word-address width (matches the 11-bit PC).
REQ-002 Parameter: DW, 32, data width.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; the ports SHALL be as listed in REQ-004 to REQ-019.
REQ-004 Port: clk  in  1  rising-edge clock.
REQ-005 Port: rst_n  in  1  asynchronous active-low reset.
REQ-006 Port: req_valid  in  1  pipeline offers a load/store.
REQ-007 Port: req_ready  out  1  unit accepts the offer this cycle.
REQ-008 Port: req_is_ldr  in  1  1 = LDR, 0 = STR.
REQ-009 Port: req_addr  in  DW  effective address (datapath_out).
REQ-010 Port: req_data  in  DW  store data (str_data).
REQ-011 Port: req_rd  in  4  LDR destination register.
REQ-012 Port: mem_addr  out  MEM_AW  RAM word address.
REQ-013 Port: mem_wdata  out  DW  RAM write data.
REQ-014 Port: mem_wren  out  1  RAM write strobe.
REQ-015 Port: mem_rdata  in  DW  RAM read data; synchronous, valid one cycle after mem_addr.
REQ-016 Port: w_data_ldr / w_addr_ldr / w_en_ldr  out  DW/4/1  regfile LDR write port.
REQ-017 Port: pend_valid  out  1  an LDR is in flight.
REQ-018 Port: pend_rd  out  4  destination of the in-flight LDR, for hazard/forwarding control.
REQ-019 Port: fault  out  1  one-cycle pulse when a request is rejected (see Configuration).

Function
REQ-020 FSM states SHALL be IDLE, ACCESS, RD_WAIT and WB.
REQ-021 req_ready SHALL be 1 only in IDLE; a handshake is req_valid & req_ready.
REQ-022 On handshake the unit SHALL register is_ldr, addr[MEM_AW-1:0], data and rd, then go to ACCESS.
REQ-023 In ACCESS, mem_addr SHALL equal the registered address.
REQ-024 In ACCESS for a STR, mem_wren=1 and mem_wdata=registered data, then IDLE (handshake at T gives write at T+1 and ready at T+2).
REQ-025 In ACCESS for an LDR, mem_wren=0, then RD_WAIT.
REQ-026 In RD_WAIT the unit SHALL capture mem_rdata into the writeback register, then go to WB.
REQ-027 In WB, w_en_ldr=1 for exactly one cycle with the captured data and rd, then IDLE (handshake at T gives w_en_ldr at T+3).
REQ-028 pend_valid SHALL be 1 from the cycle after an LDR handshake through the WB cycle inclusive; pend_rd SHALL hold that rd.
REQ-029 Address bits above MEM_AW-1 SHALL be ignored unless MEM_RANGE_CHECK_EN is defined; there is no wrap logic beyond truncation.
REQ-030 req_valid outside IDLE SHALL be ignored with no state change; the requester holds its request.
REQ-031 rd=15 SHALL be written back like any other register.
REQ-032 mem_wren SHALL never be 1 outside ACCESS.
REQ-033 w_en_ldr SHALL never be 1 outside WB.

Reset
REQ-034 When rst_n=0, the unit SHALL go to IDLE immediately and asynchronously.
REQ-035 During reset, all outputs SHALL be 0 except req_ready, which is 1 once rst_n is released.
REQ-036 A reset mid-operation SHALL abort it: no mem_wren and no w_en_ldr after the reset asserts.

Configuration
REQ-037 With MEM_RANGE_CHECK_EN defined, a handshaked request with req_addr[DW-1:MEM_AW]!=0 SHALL pulse fault on the cycle after the handshake.
REQ-038 Such a rejected request SHALL make no memory access and no writeback, and the unit SHALL return to IDLE.
REQ-039 Without MEM_RANGE_CHECK_EN, fault SHALL be tied to 0 and the upper address bits SHALL be ignored.

Structure
REQ-040 A shared package mem_pkg SHALL hold the FSM state enum typedef and the MEM_AW/DW default constants.
REQ-041 No sub-module is required; the block SHALL consist of a single FSM plus request and writeback registers.

Verification
REQ-042 STR of addr 0x10, data 0xDEADBEEF handshaked at T -> mem_wren=1, mem_addr=0x010, mem_wdata=0xDEADBEEF at T+1; req_ready=1 at T+2; w_en_ldr stays 0.
REQ-043 LDR of addr 0x10, rd=3 after REQ-042 (RAM model) -> w_en_ldr=1, w_addr_ldr=3, w_data_ldr=0xDEADBEEF at T+3; pend_valid=1, pend_rd=3 from T+1 to T+3.
REQ-044 req_valid held high with a new STR during an LDR's RD_WAIT -> not accepted until IDLE; exactly one mem_wren, after the LDR's w_en_ldr.
REQ-045 rst_n pulsed low during an LDR's RD_WAIT -> w_en_ldr never asserts; outputs are 0 during reset; req_ready=1 the first cycle after release.
REQ-046 With MEM_RANGE_CHECK_EN, STR to 0x00000800 -> fault pulse at T+1, no mem_wren; without the macro -> write to mem_addr 0x000, fault=0.
REQ-047 Back-to-back LDRs with rd=15 then rd=0 -> two writebacks in order, with w_addr_ldr=15 then w_addr_ldr=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and default sizes for the load/store memory access unit.
package mem_pkg;

    localparam int MEM_AW_DEF = 11;
    localparam int DW_DEF     = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RD_WAIT = 2'd2,
        WB      = 2'd3
    } mem_state_e;

endpackage

// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline, a synchronous-read RAM and the register file LDR port.
// Optional MEM_RANGE_CHECK_EN rejects requests whose address does not fit the RAM word address.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int MEM_AW = MEM_AW_DEF,
    parameter int DW     = DW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_ldr,
    input  logic [DW-1:0]     req_addr,
    input  logic [DW-1:0]     req_data,
    input  logic [3:0]        req_rd,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DW-1:0]     mem_wdata,
    output logic              mem_wren,
    input  logic [DW-1:0]     mem_rdata,
    output logic [DW-1:0]     w_data_ldr,
    output logic [3:0]        w_addr_ldr,
    output logic              w_en_ldr,
    output logic              pend_valid,
    output logic [3:0]        pend_rd,
    output logic              fault
);

    mem_state_e        state_r, state_nx;
    logic              is_ldr_r, is_ldr_nx;
    logic              err_r, err_nx;
    logic [3:0]        rd_r, rd_nx;
    logic              range_err_s;

    logic              ready_r, ready_nx;
    logic [MEM_AW-1:0] mem_addr_r, mem_addr_nx;
    logic [DW-1:0]     mem_wdata_r, mem_wdata_nx;
    logic              mem_wren_r, mem_wren_nx;
    logic [DW-1:0]     w_data_r, w_data_nx;
    logic [3:0]        w_addr_r, w_addr_nx;
    logic              w_en_r, w_en_nx;
    logic              pend_valid_r, pend_valid_nx;
    logic [3:0]        pend_rd_r, pend_rd_nx;
    logic              fault_r, fault_nx;

`ifdef MEM_RANGE_CHECK_EN
    assign range_err_s = |req_addr[DW-1:MEM_AW];
`else
    logic unused_addr_s;
    assign unused_addr_s = ^req_addr[DW-1:MEM_AW];
    assign range_err_s   = 1'b0;
`endif

    // Next state plus the next value of every output register (outputs are all flops).
    always_comb begin
        state_nx      = state_r;
        is_ldr_nx     = is_ldr_r;
        err_nx        = err_r;
        rd_nx         = rd_r;
        ready_nx      = 1'b0;
        mem_addr_nx   = {MEM_AW{1'b0}};
        mem_wdata_nx  = {DW{1'b0}};
        mem_wren_nx   = 1'b0;
        w_data_nx     = {DW{1'b0}};
        w_addr_nx     = 4'd0;
        w_en_nx       = 1'b0;
        pend_valid_nx = 1'b0;
        pend_rd_nx    = 4'd0;
        fault_nx      = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid && ready_r) begin
                    state_nx  = ACCESS;
                    is_ldr_nx = req_is_ldr;
                    err_nx    = range_err_s;
                    rd_nx     = req_rd;
                    fault_nx  = range_err_s;
                    if (!range_err_s) begin
                        mem_addr_nx   = req_addr[MEM_AW-1:0];
                        mem_wren_nx   = !req_is_ldr;
                        mem_wdata_nx  = req_is_ldr ? {DW{1'b0}} : req_data;
                        pend_valid_nx = req_is_ldr;
                        pend_rd_nx    = req_is_ldr ? req_rd : 4'd0;
                    end else begin
                        mem_addr_nx   = {MEM_AW{1'b0}};
                    end
                end else begin
                    ready_nx = 1'b1;
                end
            end
            ACCESS: begin
                if (is_ldr_r && !err_r) begin
                    state_nx      = RD_WAIT;
                    pend_valid_nx = 1'b1;
                    pend_rd_nx    = rd_r;
                end else begin
                    state_nx = IDLE;
                    ready_nx = 1'b1;
                end
            end
            RD_WAIT: begin
                // RAM data for the ACCESS-cycle address is valid now.
                state_nx      = WB;
                w_en_nx       = 1'b1;
                w_addr_nx     = rd_r;
                w_data_nx     = mem_rdata;
                pend_valid_nx = 1'b1;
                pend_rd_nx    = rd_r;
            end
            WB: begin
                state_nx = IDLE;
                ready_nx = 1'b1;
            end
            default: begin
                state_nx = IDLE;
                ready_nx = 1'b1;
            end
        endcase
    end

    // State, request and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            is_ldr_r     <= 1'b0;
            err_r        <= 1'b0;
            rd_r         <= 4'd0;
            ready_r      <= 1'b1;
            mem_addr_r   <= {MEM_AW{1'b0}};
            mem_wdata_r  <= {DW{1'b0}};
            mem_wren_r   <= 1'b0;
            w_data_r     <= {DW{1'b0}};
            w_addr_r     <= 4'd0;
            w_en_r       <= 1'b0;
            pend_valid_r <= 1'b0;
            pend_rd_r    <= 4'd0;
            fault_r      <= 1'b0;
        end else begin
            state_r      <= state_nx;
            is_ldr_r     <= is_ldr_nx;
            err_r        <= err_nx;
            rd_r         <= rd_nx;
            ready_r      <= ready_nx;
            mem_addr_r   <= mem_addr_nx;
            mem_wdata_r  <= mem_wdata_nx;
            mem_wren_r   <= mem_wren_nx;
            w_data_r     <= w_data_nx;
            w_addr_r     <= w_addr_nx;
            w_en_r       <= w_en_nx;
            pend_valid_r <= pend_valid_nx;
            pend_rd_r    <= pend_rd_nx;
            fault_r      <= fault_nx;
        end
    end

    // Ready is held low while reset is asserted even though the state is already IDLE.
    assign req_ready  = ready_r & rst_n;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign mem_wren   = mem_wren_r;
    assign w_data_ldr = w_data_r;
    assign w_addr_ldr = w_addr_r;
    assign w_en_ldr   = w_en_r;
    assign pend_valid = pend_valid_r;
    assign pend_rd    = pend_rd_r;
    assign fault      = fault_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a transaction-level timeline model.
module tb_mem_access_unit;

    localparam int MEM_AW = 11;
    localparam int DW     = 32;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_is_ldr;
    logic [DW-1:0]     req_addr;
    logic [DW-1:0]     req_data;
    logic [3:0]        req_rd;
    logic [MEM_AW-1:0] mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_wren;
    logic [DW-1:0]     mem_rdata;
    logic [DW-1:0]     w_data_ldr;
    logic [3:0]        w_addr_ldr;
    logic              w_en_ldr;
    logic              pend_valid;
    logic [3:0]        pend_rd;
    logic              fault;

    int total;
    int bad;
    int wren_cnt;
    int wen_cnt;

    logic [DW-1:0] ram     [0:(1<<MEM_AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<MEM_AW)-1];

    mem_access_unit #(.MEM_AW(MEM_AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_ldr(req_is_ldr),
        .req_addr(req_addr), .req_data(req_data), .req_rd(req_rd),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
        .mem_rdata(mem_rdata),
        .w_data_ldr(w_data_ldr), .w_addr_ldr(w_addr_ldr), .w_en_ldr(w_en_ldr),
        .pend_valid(pend_valid), .pend_rd(pend_rd), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM environment model
    always @(posedge clk) begin
        if (mem_wren === 1'b1) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // Strobe counters sample the value held during the cycle that just ended
    always @(posedge clk) begin
        if (mem_wren === 1'b1) wren_cnt = wren_cnt + 1;
        if (w_en_ldr === 1'b1) wen_cnt = wen_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit range_err(input logic [31:0] addr);
`ifdef MEM_RANGE_CHECK_EN
        return (addr[31:MEM_AW] != 21'd0);
`else
        return 1'b0;
`endif
    endfunction

    // One transaction, starting just after a negedge; returns just after the negedge where the unit is IDLE again.
    task automatic do_req(input logic ld, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] rd);
        bit err;
        bit do_st;
        bit do_ld;
        logic [MEM_AW-1:0] a;
        int waited;
        err   = range_err(addr);
        a     = addr[MEM_AW-1:0];
        do_st = !ld && !err;
        do_ld = ld && !err;
        req_valid  = 1'b1;
        req_is_ldr = ld;
        req_addr   = addr;
        req_data   = data;
        req_rd     = rd;
        waited = 0;
        while (req_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (req_ready !== 1'b1) begin
            check_val("hs_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_data  = $urandom;
        check_val("t1_fault", 32'(fault), 32'(err));
        check_val("t1_wren", 32'(mem_wren), 32'(do_st));
        check_val("t1_ready", 32'(req_ready), 32'd0);
        check_val("t1_wen", 32'(w_en_ldr), 32'd0);
        check_val("t1_pend", 32'(pend_valid), 32'(do_ld));
        if (do_st) begin
            check_val("t1_addr", 32'(mem_addr), 32'(a));
            check_val("t1_wdata", mem_wdata, data);
            ref_mem[a] = data;
        end
        if (do_ld) begin
            check_val("t1_addr_ld", 32'(mem_addr), 32'(a));
            check_val("t1_pend_rd", 32'(pend_rd), 32'(rd));
        end
        @(negedge clk);
        check_val("t2_wren", 32'(mem_wren), 32'd0);
        check_val("t2_fault", 32'(fault), 32'd0);
        check_val("t2_wen", 32'(w_en_ldr), 32'd0);
        if (!do_ld) begin
            check_val("t2_ready", 32'(req_ready), 32'd1);
            return;
        end
        check_val("t2_ready_ld", 32'(req_ready), 32'd0);
        check_val("t2_pend", 32'(pend_valid), 32'd1);
        check_val("t2_pend_rd", 32'(pend_rd), 32'(rd));
        @(negedge clk);
        check_val("t3_wen", 32'(w_en_ldr), 32'd1);
        check_val("t3_waddr", 32'(w_addr_ldr), 32'(rd));
        check_val("t3_wdata", w_data_ldr, ref_mem[a]);
        check_val("t3_pend", 32'(pend_valid), 32'd1);
        check_val("t3_pend_rd", 32'(pend_rd), 32'(rd));
        check_val("t3_wren", 32'(mem_wren), 32'd0);
        @(negedge clk);
        check_val("t4_wen", 32'(w_en_ldr), 32'd0);
        check_val("t4_pend", 32'(pend_valid), 32'd0);
        check_val("t4_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int e0;
        logic [31:0] addr;
        total = 0; bad = 0; wren_cnt = 0; wen_cnt = 0;
        for (int i = 0; i < (1 << MEM_AW); i++) begin
            ram[i]     = 32'd0;
            ref_mem[i] = 32'd0;
        end
        rst_n = 1'b0; req_valid = 1'b0; req_is_ldr = 1'b0;
        req_addr = 32'd0; req_data = 32'd0; req_rd = 4'd0;

        // Reset state
        repeat (2) @(negedge clk);
        check_val("rst_ready", 32'(req_ready), 32'd0);
        check_val("rst_wren", 32'(mem_wren), 32'd0);
        check_val("rst_wen", 32'(w_en_ldr), 32'd0);
        check_val("rst_pend", 32'(pend_valid), 32'd0);
        check_val("rst_addr", 32'(mem_addr), 32'd0);
        check_val("rst_fault", 32'(fault), 32'd0);
        rst_n = 1'b1;
        #1;
        check_val("rel_ready", 32'(req_ready), 32'd1);

        // Directed store/load pair, rd=15 then rd=0 back-to-back
        e0 = wen_cnt;
        do_req(1'b0, 32'h10, 32'hDEADBEEF, 4'd0);
        check_val("str_no_wen", 32'(wen_cnt - e0), 32'd0);
        do_req(1'b1, 32'h10, 32'd0, 4'd3);
        do_req(1'b0, 32'h11, 32'h0BADF00D, 4'd0);
        do_req(1'b1, 32'h10, 32'd0, 4'd15);
        do_req(1'b1, 32'h11, 32'd0, 4'd0);

        // Out-of-range store then read back word 0
        w0 = wren_cnt;
        do_req(1'b0, 32'h00000800, 32'h12345678, 4'd0);
        check_val("oor_wren_cnt", 32'(wren_cnt - w0), 32'(!range_err(32'h800)));
        do_req(1'b1, 32'h0, 32'd0, 4'd5);

        // Request held during an LDR: accepted only once the unit is back in IDLE
        w0 = wren_cnt; e0 = wen_cnt;
        req_valid = 1'b1; req_is_ldr = 1'b1; req_addr = 32'h10; req_rd = 4'd7;
        @(negedge clk);
        req_is_ldr = 1'b0; req_addr = 32'h20; req_data = 32'hCAFE0001;
        check_val("hold_t1_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check_val("hold_t2_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check_val("hold_t3_wen", 32'(w_en_ldr), 32'd1);
        check_val("hold_t3_wdata", w_data_ldr, ref_mem[11'h10]);
        check_val("hold_t3_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check_val("hold_t4_ready", 32'(req_ready), 32'd1);
        check_val("hold_t4_nowr", 32'(wren_cnt - w0), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        check_val("hold_t5_wren", 32'(mem_wren), 32'd1);
        check_val("hold_t5_addr", 32'(mem_addr), 32'h20);
        check_val("hold_t5_wdata", mem_wdata, 32'hCAFE0001);
        ref_mem[11'h20] = 32'hCAFE0001;
        @(negedge clk);
        check_val("hold_wr_cnt", 32'(wren_cnt - w0), 32'd1);
        check_val("hold_wen_cnt", 32'(wen_cnt - e0), 32'd1);
        check_val("hold_t6_ready", 32'(req_ready), 32'd1);

        // Reset during RD_WAIT aborts the load
        e0 = wen_cnt;
        req_valid = 1'b1; req_is_ldr = 1'b1; req_addr = 32'h20; req_rd = 4'd9;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("ar_ready", 32'(req_ready), 32'd0);
        check_val("ar_pend", 32'(pend_valid), 32'd0);
        check_val("ar_pend_rd", 32'(pend_rd), 32'd0);
        check_val("ar_wen", 32'(w_en_ldr), 32'd0);
        check_val("ar_wren", 32'(mem_wren), 32'd0);
        @(negedge clk);
        check_val("ar_wen2", 32'(w_en_ldr), 32'd0);
        rst_n = 1'b1;
        #1;
        check_val("ar_rel_ready", 32'(req_ready), 32'd1);
        repeat (4) @(negedge clk);
        check_val("ar_no_wb", 32'(wen_cnt - e0), 32'd0);

        // Randomized mix; mostly in-range addresses so loads hit earlier stores
        for (int n = 0; n < 80; n++) begin
            addr = 32'($urandom_range(0, 31));
            if ($urandom_range(0, 5) == 0) addr = addr | ($urandom & 32'hFFFF_F800);
            do_req(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
